// File: rtl/matmul_ctrl.sv
// Sequencer for the matrix multiplier: loads A and B from two readers, feeds every
// row-column operand stream to an external MAC, then streams C = A x B out row-major.
module matmul_ctrl #(
  parameter  int n  = 8,
  localparam int IW = $clog2(n)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          done,

  output logic          a_start,
  input  logic [IW-1:0] a_i,
  input  logic [IW-1:0] a_j,
  input  logic [31:0]   a_value,
  input  logic          a_stb,
  output logic          a_ack,
  input  logic          a_done,

  output logic          b_start,
  input  logic [IW-1:0] b_i,
  input  logic [IW-1:0] b_j,
  input  logic [31:0]   b_value,
  input  logic          b_stb,
  output logic          b_ack,
  input  logic          b_done,

  output logic [31:0]   mac_a,
  output logic [31:0]   mac_b,
  output logic          mac_clr,
  output logic          mac_last,
  output logic          mac_stb,
  input  logic          mac_ack,
  input  logic [31:0]   mac_z,
  input  logic          mac_z_stb,
  output logic          mac_z_ack,

  output logic [IW-1:0] c_i,
  output logic [IW-1:0] c_j,
  output logic [31:0]   c_value,
  output logic          c_stb,
  input  logic          c_ack
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_ISSUE, S_WAIT_Z, S_OUTPUT, S_DONE
  } state_t;

  localparam logic [IW-1:0] LAST = IW'(n - 1);

  state_t        state;
  logic [IW-1:0] i, j, k;
  logic [31:0]   buf_a [n][n];
  logic [31:0]   buf_b [n][n];

  logic          row_last;
  logic [IW-1:0] next_i, next_j, k_inc;

  // NOTE: every signal driven in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    row_last = (j == LAST);
    next_i   = row_last ? i + 1'b1 : i;
    next_j   = row_last ? '0 : j + 1'b1;
    k_inc    = k + 1'b1;
  end

  // NOTE: the operand buffers are plain storage with no reset; every entry is written before it is read.
  always_ff @(posedge clk) begin
    if (a_stb && a_ack) buf_a[a_i][a_j] <= a_value;
    if (b_stb && b_ack) buf_b[b_i][b_j] <= b_value;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      i         <= '0;
      j         <= '0;
      k         <= '0;
      done      <= 1'b0;
      a_start   <= 1'b0;
      a_ack     <= 1'b0;
      b_start   <= 1'b0;
      b_ack     <= 1'b0;
      mac_a     <= '0;
      mac_b     <= '0;
      mac_clr   <= 1'b0;
      mac_last  <= 1'b0;
      mac_stb   <= 1'b0;
      mac_z_ack <= 1'b0;
      c_i       <= '0;
      c_j       <= '0;
      c_value   <= '0;
      c_stb     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_LOAD_A;
            a_start <= 1'b1;
            a_ack   <= 1'b1;
          end
        end

        S_LOAD_A: begin
          a_start <= 1'b0;
          if (a_done) begin
            state   <= S_LOAD_B;
            a_ack   <= 1'b0;
            b_start <= 1'b1;
            b_ack   <= 1'b1;
          end
        end

        S_LOAD_B: begin
          b_start <= 1'b0;
          if (b_done) begin
            state    <= S_ISSUE;
            b_ack    <= 1'b0;
            i        <= '0;
            j        <= '0;
            k        <= '0;
            mac_stb  <= 1'b1;
            mac_clr  <= 1'b1;
            mac_last <= 1'b0;
            mac_a    <= buf_a[0][0];
            // A final B element landing on this same edge is not in the buffer yet.
            mac_b    <= (b_stb && b_i == '0 && b_j == '0) ? b_value : buf_b[0][0];
          end
        end

        S_ISSUE: begin
          if (mac_ack) begin
            if (k == LAST) begin
              state     <= S_WAIT_Z;
              k         <= '0;
              mac_stb   <= 1'b0;
              mac_clr   <= 1'b0;
              mac_last  <= 1'b0;
              mac_z_ack <= 1'b1;
            end else begin
              k        <= k_inc;
              mac_a    <= buf_a[i][k_inc];
              mac_b    <= buf_b[k_inc][j];
              mac_clr  <= 1'b0;
              mac_last <= (k_inc == LAST);
            end
          end
        end

        S_WAIT_Z: begin
          if (mac_z_stb) begin
            state     <= S_OUTPUT;
            mac_z_ack <= 1'b0;
            c_value   <= mac_z;
            c_i       <= i;
            c_j       <= j;
            c_stb     <= 1'b1;
          end
        end

        S_OUTPUT: begin
          if (c_ack) begin
            c_stb <= 1'b0;
            if (i == LAST && j == LAST) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              // Next dot product starts only after the consumer took this result.
              state    <= S_ISSUE;
              i        <= next_i;
              j        <= next_j;
              mac_stb  <= 1'b1;
              mac_clr  <= 1'b1;
              mac_last <= 1'b0;
              mac_a    <= buf_a[next_i][0];
              mac_b    <= buf_b[0][next_j];
            end
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
